// File: rtl/display_bcd_formatter.sv
// Sequential binary-to-BCD formatter feeding the 8-digit seven-segment driver.
// Double-dabble runs one bit per cycle; results reach the outputs only at the commit edge.
module display_bcd_formatter #(
    parameter int WIDTH = 27
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_value,
    input  logic [3:0]       i_dot_pos,
    output logic             o_ready,
    output logic [3:0]       o_numbers [0:7],
    output logic             o_dots    [0:7],
    output logic             o_overflow,
    output logic             o_done
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  CONVERT   = 2'd1;
    localparam logic [1:0]  COMMIT    = 2'd2;
    localparam logic [4:0]  LAST_ITER = 5'(WIDTH - 1);
    localparam logic [31:0] OVF_LIMIT = 32'd100_000_000;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d;
    logic [31:0]      bcdAdj;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       dot_q, dot_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       numbers_q [0:7];
    logic [3:0]       numbers_d [0:7];
    logic             dots_q [0:7];
    logic             dots_d [0:7];
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             valueOvf;

    // Only a 27-bit input can reach 100_000_000, so narrower builds never flag overflow.
    assign valueOvf = (32'(i_value) >= OVF_LIMIT);

    always_comb begin
        bcdAdj = bcd_q;
        for (int k = 0; k < 8; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcdAdj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dot_d      = dot_q;
        ovf_d      = ovf_q;
        numbers_d  = numbers_q;
        dots_d     = dots_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    bin_d   = i_value;
                    bcd_d   = '0;
                    dot_d   = i_dot_pos;
                    ovf_d   = valueOvf;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Overflowed values shift a ninth digit out of the top; that result is discarded.
                {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
                if (cnt_q == LAST_ITER) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                for (int k = 0; k < 8; k++) begin
                    numbers_d[k] = ovf_q ? 4'hE : bcd_q[4*k +: 4];
                    dots_d[k]    = (dot_q == 4'(k));
                end
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            dot_q      <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                numbers_q[k] <= 4'h0;
                dots_q[k]    <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dot_q      <= dot_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            numbers_q  <= numbers_d;
            dots_q     <= dots_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_numbers  = numbers_q;
    assign o_dots     = dots_q;
    assign o_overflow = overflow_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_display_bcd_formatter.sv
// Bench for display_bcd_formatter: decimal reference model checked every cycle,
// plus directed cases with literal expectations and a randomized sweep.
module tb_display_bcd_formatter;

    localparam int WIDTH   = 27;
    localparam int LATENCY = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic [WIDTH-1:0] value;
    logic [3:0]       dotPos;
    logic             ready;
    logic [3:0]       numbers [0:7];
    logic             dots [0:7];
    logic             overflow;
    logic             done;

    int checks   = 0;
    int failures = 0;

    display_bcd_formatter #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .i_value    (value),
        .i_dot_pos  (dotPos),
        .o_ready    (ready),
        .o_numbers  (numbers),
        .o_dots     (dots),
        .o_overflow (overflow),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] packDigits();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = numbers[k];
        return r;
    endfunction

    function automatic logic [7:0] packDots();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = dots[k];
        return r;
    endfunction

    // Reference: plain decimal division, 'E' on every digit past eight digits.
    function automatic logic [31:0] decimalDigits(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        if (v >= 100_000_000) return 32'hEEEE_EEEE;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] dotMask(input logic [3:0] d);
        logic [7:0] m;
        m = '0;
        if (d < 4'd8) m[d[2:0]] = 1'b1;
        return m;
    endfunction

    // Transaction-level model: a request is busy for LATENCY edges, then its result appears.
    int unsigned cycle       = 0;
    bit          busy        = 1'b0;
    int          remaining   = 0;
    int unsigned pendVal     = 0;
    logic [3:0]  pendDot     = 4'd8;
    logic [31:0] expDigits   = '0;
    logic [7:0]  expDots     = '0;
    bit          expOvf      = 1'b0;
    bit          expDone     = 1'b0;
    int unsigned acceptCycle = 0;
    int          convCount   = 0;

    always @(posedge clk) begin
        cycle++;
        expDone = 1'b0;
        if (rst) begin
            busy      = 1'b0;
            expDigits = '0;
            expDots   = '0;
            expOvf    = 1'b0;
        end else if (busy) begin
            remaining--;
            if (remaining == 0) begin
                expDigits = decimalDigits(pendVal);
                expDots   = dotMask(pendDot);
                expOvf    = (pendVal >= 100_000_000);
                expDone   = 1'b1;
                busy      = 1'b0;
                convCount++;
            end
        end else if (valid) begin
            busy        = 1'b1;
            remaining   = LATENCY;
            pendVal     = int'(value);
            pendDot     = dotPos;
            acceptCycle = cycle;
        end
    end

    always @(negedge clk) begin
        checkValue("model_digits", packDigits(), expDigits);
        checkValue("model_dots", 32'(packDots()), 32'(expDots));
        checkValue("model_overflow", 32'(overflow), 32'(expOvf));
        checkValue("model_ready", 32'(ready), 32'(!busy));
        checkValue("model_done", 32'(done), 32'(expDone));
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] v, input logic [3:0] d);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkValue("ready_timeout", 32'(ready), 32'd1);
        valid  = 1'b1;
        value  = v;
        dotPos = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic waitDone(output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkValue("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] d, input logic [7:0] m, input logic o);
        checkValue({name, "_digits"}, packDigits(), d);
        checkValue({name, "_dots"}, 32'(packDots()), 32'(m));
        checkValue({name, "_overflow"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        int w;
        int unsigned firstAcc, secondAcc;
        int sawDone, startConv, guard, sel;

        rst    = 1'b1;
        valid  = 1'b0;
        value  = '0;
        dotPos = 4'd8;
        repeat (2) @(negedge clk);
        checkOutput("reset", 32'h0, 8'h00, 1'b0);
        checkValue("reset_ready", 32'(ready), 32'd1);
        checkValue("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(27'd12_345_678, 4'd3);
        waitDone(w);
        checkValue("latency_first", w, LATENCY);
        checkOutput("basic", 32'h1234_5678, 8'b0000_1000, 1'b0);

        applyStimulus(27'd0, 4'd8);
        waitDone(w);
        checkOutput("zero", 32'h0000_0000, 8'h00, 1'b0);
        applyStimulus(27'd99_999_999, 4'd8);
        waitDone(w);
        checkOutput("max", 32'h9999_9999, 8'h00, 1'b0);
        applyStimulus(27'd100_000_000, 4'd8);
        waitDone(w);
        checkValue("latency_overflow", w, LATENCY);
        checkOutput("overflow", 32'hEEEE_EEEE, 8'h00, 1'b1);

        // Busy-drop: 42 held valid through the conversion of 7.
        valid  = 1'b1;
        value  = 27'd7;
        dotPos = 4'd8;
        @(negedge clk);
        firstAcc = acceptCycle;
        value = 27'd42;
        waitDone(w);
        checkOutput("busy_first", 32'h0000_0007, 8'h00, 1'b0);
        @(negedge clk);
        secondAcc = acceptCycle;
        valid = 1'b0;
        checkValue("accept_gap", secondAcc - firstAcc, 32'd29);
        waitDone(w);
        checkValue("latency_second", w, LATENCY);
        checkOutput("busy_second", 32'h0000_0042, 8'h00, 1'b0);

        applyStimulus(27'd55_555_555, 4'd15);
        waitDone(w);
        checkOutput("fives", 32'h5555_5555, 8'h00, 1'b0);
        applyStimulus(27'd1, 4'd0);
        for (int i = 0; i < LATENCY; i++) begin
            checkValue("stable_hold", packDigits(), 32'h5555_5555);
            @(negedge clk);
        end
        waitDone(w);
        checkOutput("one", 32'h0000_0001, 8'h01, 1'b0);

        applyStimulus(27'd87_654_321, 4'd2);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset", 32'h0, 8'h00, 1'b0);
        checkValue("midreset_ready", 32'(ready), 32'd1);
        checkValue("midreset_done", 32'(done), 32'd0);
        rst = 1'b0;
        sawDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone++;
        end
        checkValue("midreset_no_done", sawDone, 0);
        checkValue("midreset_idle", 32'(ready), 32'd1);

        startConv = convCount;
        guard = 0;
        while (convCount - startConv < 1000 && guard < 60000) begin
            valid = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 7);
            case (sel)
                0:       value = 27'd0;
                1:       value = 27'd99_999_999;
                2:       value = 27'd100_000_000;
                3, 4:    value = 27'($urandom_range(0, 99_999_999));
                default: value = 27'($urandom);
            endcase
            dotPos = 4'($urandom_range(0, 15));
            @(negedge clk);
            guard++;
        end
        valid = 1'b0;
        checkValue("random_count", 32'(convCount - startConv >= 1000), 32'd1);
        repeat (LATENCY + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
